// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, widths and key-vector helpers for the keypad front end.
package keypad_pkg;
    localparam int KEY_W = 10;
    localparam int CODE_W = 4;
    localparam logic [KEY_W-1:0] KEY_NONE = '0;

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return $onehot(v);
    endfunction

    function automatic logic [CODE_W-1:0] onehot_to_code(input logic [KEY_W-1:0] v);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < KEY_W; i++)
            if (v[i]) c = CODE_W'(i);
        return c;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous level inputs, cleared by rst.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: synchronise and debounce a 10-key pad into one clean press event per key press.
// Defining KEYPAD_REPEAT_EN adds auto-repeat strobes while a valid key stays held.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_PERIOD = 200
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_raw,
    output logic [KEY_W-1:0]  key_onehot,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_error
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [KEY_W-1:0] s, cand;
    logic [CW-1:0]    cnt;
    state_t           state;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [RW-1:0] rcnt;
`endif

    sync_2ff #(.W(KEY_W)) u_sync (.clk(clk), .rst(rst), .d(key_raw), .q(s));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cand       <= KEY_NONE;
            key_onehot <= KEY_NONE;
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_error  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt       <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            key_error <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt      <= '0;
`endif
            case (state)
                IDLE: if (s != KEY_NONE) begin
                    cand  <= s;
                    cnt   <= '0;
                    state <= DB_PRESS;
                end
                DB_PRESS: if (s == KEY_NONE) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else if (s != cand) begin
                    cand <= s;
                    cnt  <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt   <= '0;
                    state <= HELD;
                    // a multi-key chord still parks in HELD so it cannot re-fire until fully released
                    if (is_onehot(cand)) begin
                        key_onehot <= cand;
                        key_code   <= onehot_to_code(cand);
                        key_valid  <= 1'b1;
                    end else begin
                        key_error <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                HELD: if (s == KEY_NONE) begin
                    cnt   <= '0;
                    state <= DB_RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (key_onehot != KEY_NONE) begin
                    rcnt      <= (rcnt == RPT_MAX) ? RPT_RELOAD : rcnt + 1'b1;
                    key_valid <= (rcnt == RPT_MAX);
                end
`endif
                DB_RELEASE: if (s != KEY_NONE) begin
                    cnt   <= '0;
                    state <= HELD;
                end else if (cnt == CNT_MAX) begin
                    cnt        <= '0;
                    key_onehot <= KEY_NONE;
                    state      <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: directed and random stimulus against a run-length reference model of the debouncer.
module tb_keypad_debounce;
    localparam int DEB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key_raw = '0;
    logic [9:0] key_onehot;
    logic [3:0] key_code;
    logic       key_valid, key_error;

    int errors = 0;
    int checks = 0;

    // reference model state: raw pipeline, stable-run length, pressed/released mode
    logic [9:0] p1, p2, last, m_onehot;
    logic [3:0] m_code;
    logic       m_valid, m_err, held, zprev;
    int         run, rc;

    always #5 clk = ~clk;

    keypad_debounce #(
        .DEBOUNCE_CYC(DEB)
`ifdef KEYPAD_REPEAT_EN
        , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw),
        .key_onehot(key_onehot), .key_code(key_code),
        .key_valid(key_valid), .key_error(key_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] key_index(input logic [9:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    // one clock: drive inputs, advance the model, then compare on the falling edge
    task automatic step(input logic r, input logic [9:0] k);
        logic [9:0] s;
        rst = r;
        key_raw = k;
        if (r) begin
            p1 = '0; p2 = '0; last = '0; m_onehot = '0; m_code = '0;
            m_valid = 0; m_err = 0; held = 0; zprev = 0; run = 0; rc = 0;
        end else begin
            s = p2; p2 = p1; p1 = k;
            m_valid = 0; m_err = 0;
            if (!held) begin
                run = (s != 0 && s == last) ? run + 1 : (s != 0 ? 1 : 0);
                last = s;
                if (run == DEB + 1) begin
                    held = 1; run = 0; rc = 0; zprev = 0;
                    if ($countones(s) == 1) begin
                        m_onehot = s; m_code = key_index(s); m_valid = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else begin
                run = (s == 0) ? run + 1 : 0;
`ifdef KEYPAD_REPEAT_EN
                if (s == 0) begin
                    rc = 0; zprev = 1;
                end else if (zprev) begin
                    zprev = 0;
                end else if (m_onehot != 0) begin
                    rc++;
                    if (rc == RD) begin m_valid = 1; rc = RD - RP; end
                end
`endif
                if (run == DEB + 1) begin
                    held = 0; run = 0; last = '0; m_onehot = '0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("onehot", key_onehot, m_onehot);
        check("code", key_code, m_code);
        check("valid", key_valid, m_valid);
        check("error", key_error, m_err);
        check("strobe_excl", key_valid & key_error, 0);
    endtask

    task automatic run_key(input logic [9:0] k, input int n, output int first, output int nval, output int nerr);
        first = 0; nval = 0; nerr = 0;
        for (int i = 0; i < n; i++) begin
            step(0, k);
            if (key_valid) begin
                nval++;
                if (first == 0) first = i + 1;
            end
            if (key_error) nerr++;
        end
    endtask

    initial begin
        int first, nval, nerr;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1, '0);
        check("reset_onehot", key_onehot, 0);
        check("reset_code", key_code, 0);

        // clean press of key 3
        run_key(10'h008, 16, first, nval, nerr);
        check("t1_latency", first, DEB + 3);
        check("t1_count", nval, 1);
        check("t1_code", key_code, 3);
        check("t1_onehot", key_onehot, 10'h008);
        run_key(10'h000, 12, first, nval, nerr);

        // bouncing key 5 then settled
        for (int i = 0; i < 6; i++) begin
            run_key(10'h020, 2, first, nval, nerr);
            check("t2_bounce_hi", nval, 0);
            run_key(10'h000, 2, first, nval, nerr);
            check("t2_bounce_lo", nval, 0);
        end
        run_key(10'h020, 12, first, nval, nerr);
        check("t2_latency", first, DEB + 3);
        check("t2_code", key_code, 5);
        run_key(10'h000, 12, first, nval, nerr);

        // chord rejected, then a clean key 9
        run_key(10'h003, 12, first, nval, nerr);
        check("t3_err", nerr, 1);
        check("t3_noval", nval, 0);
        check("t3_onehot", key_onehot, 0);
        run_key(10'h000, 12, first, nval, nerr);
        run_key(10'h200, 12, first, nval, nerr);
        check("t3_val", nval, 1);
        check("t3_code", key_code, 9);
        run_key(10'h000, 12, first, nval, nerr);

        // second key added and first released while held
        run_key(10'h004, 10, first, nval, nerr);
        run_key(10'h084, 5, first, nval, nerr);
`ifndef KEYPAD_REPEAT_EN
        check("t4_add_ignored", nval + nerr, 0);
`endif
        run_key(10'h080, 5, first, nval, nerr);
`ifndef KEYPAD_REPEAT_EN
        check("t4_swap_ignored", nval + nerr, 0);
`endif
        check("t4_onehot_held", key_onehot, 10'h004);
        first = 0;
        for (int i = 0; i < 12 && first == 0; i++) begin
            step(0, 10'h000);
            if (key_onehot == 0) first = i + 1;
        end
        check("t4_release_latency", first, DEB + 3);
        run_key(10'h000, 6, first, nval, nerr);

        // reset during hold with key 4 still pressed
        run_key(10'h010, 10, first, nval, nerr);
        step(1, 10'h010);
        check("t5_rst_onehot", key_onehot, 0);
        check("t5_rst_code", key_code, 0);
        run_key(10'h010, 12, first, nval, nerr);
        check("t5_refire", first, DEB + 3);
        check("t5_code", key_code, 4);
        run_key(10'h000, 12, first, nval, nerr);

`ifdef KEYPAD_REPEAT_EN
        run_key(10'h002, DEB + 3 + 30, first, nval, nerr);
        check("t6_repeat_count", nval, 6);
        run_key(10'h000, 12, first, nval, nerr);
`endif

        // random segments, occasional chords and resets
        for (int seg = 0; seg < 300; seg++) begin
            int sel;
            logic [9:0] k;
            sel = $urandom_range(0, 9);
            k = '0;
            if (sel <= 5) k[$urandom_range(0, 9)] = 1'b1;
            else if (sel == 8) begin
                k[$urandom_range(0, 9)] = 1'b1;
                k[$urandom_range(0, 9)] = 1'b1;
            end
            if (sel == 9) step(1, 10'($urandom_range(0, 1023)));
            else run_key(k, $urandom_range(1, 14), first, nval, nerr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
